// File: rtl/read_burst_seq_pkg.sv
// Shared state encoding and parameter checks for the read burst sequencer.
// One-hot states so outputs decode from single state bits.
package read_burst_pkg;

  localparam int I_IDLE = 0;
  localparam int I_READ = 1;
  localparam int I_DLY  = 2;
  localparam int I_DONE = 3;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    READ = 4'b0010,
    DLY  = 4'b0100,
    DONE = 4'b1000
  } state_e;

  function automatic string state_name(state_e s);
    case (s)
      IDLE:    return "IDLE";
      READ:    return "READ";
      DLY:     return "DLY";
      DONE:    return "DONE";
      default: return "ILLEGAL";
    endcase
  endfunction

  function automatic bit max_retry_ok(int m);
    return m >= 1;
  endfunction

endpackage

// File: rtl/read_burst_seq_if.sv
// Command-side and slave-side signals of the read burst sequencer.
// master drives commands and ws; slave is the sequencer.
interface read_burst_seq_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
);
  logic              go;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] base_addr;
  logic              ws;
  logic              rd;
  logic              rs;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              done;
  logic              timeout;

  modport master (
    output go, len, base_addr, ws,
    input  rd, rs, addr, busy, done, timeout
  );

  modport slave (
    input  go, len, base_addr, ws,
    output rd, rs, addr, busy, done, timeout
  );
endinterface

// File: rtl/read_burst_seq_counter.sv
// Address, remaining-beat and per-beat retry counters.
// Controls are mutually exclusive; load has priority.
module read_beat_counter
  import read_burst_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int LEN_W     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              beat_adv,
  input  logic              retry_inc,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              last_beat,
  output logic              retry_exhausted
);

  localparam int RC_W = $clog2(MAX_RETRY + 1);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(MAX_RETRY);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [RC_W-1:0]   retry_q, retry_d;

  always_comb begin
    addr_d  = addr_q;
    beats_d = beats_q;
    retry_d = retry_q;
    if (load) begin
      addr_d  = base_addr;
      beats_d = len;
      retry_d = '0;
    end else if (beat_adv) begin
      addr_d  = addr_q + ADDR_W'(1);
      beats_d = beats_q - LEN_W'(1);
      retry_d = '0;
    end else if (retry_inc) begin
      retry_d = retry_q + RC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      beats_q <= '0;
      retry_q <= '0;
    end else begin
      addr_q  <= addr_d;
      beats_q <= beats_d;
      retry_q <= retry_d;
    end
  end

  assign addr            = addr_q;
  assign last_beat       = (beats_q == '0);
  assign retry_exhausted = (retry_q == RC_MAX);

endmodule

// File: rtl/read_burst_seq.sv
// Read burst sequencer: LEN+1 read strobes with per-beat wait-state retry.
// FSM here; counters in read_beat_counter.
module read_burst_seq
  import read_burst_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int LEN_W     = 4,
  parameter int MAX_RETRY = 3
) (
  input logic            clk,
  input logic            rst,
  read_burst_seq_if.slave bus
);

  if (!max_retry_ok(MAX_RETRY)) begin : g_bad_retry
    $error("read_burst_seq: MAX_RETRY must be >= 1");
  end

  state_e state_q, state_d;
  logic   timeout_q, timeout_d;
  logic   load, beat_adv, retry_inc;
  logic   last_beat, retry_exhausted;

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    load      = 1'b0;
    beat_adv  = 1'b0;
    retry_inc = 1'b0;
    unique case (1'b1)
      state_q[I_IDLE]: begin
        timeout_d = 1'b0;
        if (bus.go) begin
          load    = 1'b1;
          state_d = READ;
        end
      end
      state_q[I_READ]: state_d = DLY;
      state_q[I_DLY]: begin
        if (bus.ws) begin
          if (retry_exhausted) begin
            timeout_d = 1'b1;
            state_d   = DONE;
          end else begin
            retry_inc = 1'b1;
            state_d   = READ;
          end
        end else if (last_beat) begin
          state_d = DONE;
        end else begin
          beat_adv = 1'b1;
          state_d  = READ;
        end
      end
      state_q[I_DONE]: begin
        timeout_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        timeout_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  read_beat_counter #(
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .MAX_RETRY(MAX_RETRY)
  ) u_cnt (
    .clk            (clk),
    .rst            (rst),
    .load           (load),
    .beat_adv       (beat_adv),
    .retry_inc      (retry_inc),
    .len            (bus.len),
    .base_addr      (bus.base_addr),
    .addr           (bus.addr),
    .last_beat      (last_beat),
    .retry_exhausted(retry_exhausted)
  );

  assign bus.rd      = state_q[I_READ];
  assign bus.rs      = state_q[I_READ] | state_q[I_DLY];
  assign bus.busy    = ~state_q[I_IDLE];
  assign bus.done    = state_q[I_DONE];
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_read_burst_seq.sv
// Directed and random bursts against a trace model of the read sequencer.
// Expected per-cycle outputs are built from the burst rules before each run.
module tb_read_burst_seq;

  localparam int AW   = 8;
  localparam int LW   = 4;
  localparam int MAXR = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  read_burst_seq_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

  read_burst_seq #(
    .ADDR_W   (AW),
    .LEN_W    (LW),
    .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit         rd;
    bit         rs;
    bit         done;
    bit         to;
    bit         ws;
    logic [7:0] addr;
  } cyc_t;

  cyc_t tr[$];
  int   checks = 0;
  int   errors = 0;
  int   rd_seen;
  int   burst_id = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pick_ws(int mode, int dly_idx);
    case (mode)
      0:       return 1'b0;
      1:       return dly_idx == 0;
      2:       return 1'b1;
      default: return $urandom_range(0, 99) < 45;
    endcase
  endfunction

  // Expected trace: every attempt is a READ cycle then a DLY cycle.
  task automatic build(int len, int base, int mode);
    cyc_t c;
    int   dly = 0;
    bit   to = 0;
    logic [7:0] a = 8'(base);
    tr.delete();
    for (int b = 0; b <= len && !to; b++) begin
      a = 8'(base + b);
      for (int k = 0; ; k++) begin
        c = '{rd: 1, rs: 1, done: 0, to: 0, ws: 1'($urandom), addr: a};
        tr.push_back(c);
        c = '{rd: 0, rs: 1, done: 0, to: 0, ws: pick_ws(mode, dly), addr: a};
        dly++;
        tr.push_back(c);
        if (!c.ws) break;
        if (k == MAXR) begin
          to = 1;
          break;
        end
      end
    end
    c = '{rd: 0, rs: 0, done: 1, to: to, ws: 1'($urandom), addr: a};
    tr.push_back(c);
  endtask

  task automatic chk_zero(string tag, bit with_addr);
    chk({tag, " rd"}, 32'(bus.rd), 0);
    chk({tag, " rs"}, 32'(bus.rs), 0);
    chk({tag, " busy"}, 32'(bus.busy), 0);
    chk({tag, " done"}, 32'(bus.done), 0);
    chk({tag, " timeout"}, 32'(bus.timeout), 0);
    if (with_addr) chk({tag, " addr"}, 32'(bus.addr), 0);
  endtask

  task automatic run(int len, int base, int mode, int abort_at, bit noise_go);
    string t;
    burst_id++;
    build(len, base, mode);
    @(negedge clk);
    bus.go        = 1'b1;
    bus.len       = LW'(len);
    bus.base_addr = AW'(base);
    bus.ws        = 1'($urandom);
    @(posedge clk);
    #1;
    bus.go        = 1'b0;
    bus.len       = LW'($urandom);
    bus.base_addr = AW'($urandom);
    rd_seen       = 0;
    for (int i = 0; i < tr.size(); i++) begin
      t = $sformatf("b%0d c%0d", burst_id, i);
      bus.ws = tr[i].ws;
      bus.go = noise_go ? 1'($urandom) : 1'b0;
      if (i == abort_at) rst = 1'b1;
      chk({t, " rd"}, 32'(bus.rd), 32'(tr[i].rd));
      chk({t, " rs"}, 32'(bus.rs), 32'(tr[i].rs));
      chk({t, " addr"}, 32'(bus.addr), 32'(tr[i].addr));
      chk({t, " busy"}, 32'(bus.busy), 1);
      chk({t, " done"}, 32'(bus.done), 32'(tr[i].done));
      chk({t, " timeout"}, 32'(bus.timeout), 32'(tr[i].to));
      rd_seen += int'(bus.rd);
      @(posedge clk);
      #1;
      if (i == abort_at) begin
        rst    = 1'b0;
        bus.go = 1'b0;
        chk_zero($sformatf("b%0d abort", burst_id), 1);
        return;
      end
    end
    bus.go = 1'b0;
    chk_zero($sformatf("b%0d idle", burst_id), 0);
  endtask

  initial begin
    int len, base, ab;
    rst           = 1'b1;
    bus.go        = 1'b1;
    bus.len       = '0;
    bus.base_addr = 8'hAA;
    bus.ws        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset", 1);
    rst    = 1'b0;
    bus.go = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("post reset idle", 1);

    run(0, 'h10, 0, -1, 0);
    chk("single rd count", 32'(rd_seen), 1);

    run(3, 'h20, 0, -1, 0);
    chk("burst4 rd count", 32'(rd_seen), 4);
    chk("burst4 busy cycles", 32'(tr.size()), 9);

    run(1, 'h00, 1, -1, 0);
    chk("retry rd count", 32'(rd_seen), 3);

    run(0, 'h40, 2, -1, 0);
    chk("timeout rd count", 32'(rd_seen), MAXR + 1);

    run(2, 'hFE, 0, -1, 1);
    chk("wrap rd count", 32'(rd_seen), 3);

    run(3, 'h30, 0, 3, 0);
    run(1, 'h55, 0, -1, 0);
    chk("after abort rd count", 32'(rd_seen), 2);

    for (int n = 0; n < 40; n++) begin
      len  = $urandom_range(0, (1 << LW) - 1);
      base = $urandom_range(0, (1 << AW) - 1);
      ab   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2 * len + 1) : -1;
      run(len, base, 3, ab, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
